// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Brief    : Shared loader state encoding and frame marker default.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_SYNC = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_RUN  = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/cpu_prog_mem.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_prog_mem
//  Brief    : 2**AW x 8 program memory, synchronous write, asynchronous read.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_prog_mem #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_q [2**AW];

    // No reset: program contents survive a CPU/loader reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/cpu_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_prog_loader
//  Brief    : Byte-stream framed program loader in front of a program memory;
//             holds the CPU in reset until a checksum-valid frame is stored.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_prog_loader
    import cpu_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int         AW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    input  logic [AW-1:0] adress,
    output logic [7:0]    dout_rom,
    output logic          cpu_reset,
    output logic          done,
    output logic          error,
    output logic [7:0]    byte_count
);

    state_t        state_q, state_d;
    logic [8:0]    rem_q, rem_d;
    logic [7:0]    sum_q, sum_d;
    logic [7:0]    byte_count_q, byte_count_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          xfer_w;
    logic          we_w;
    logic [7:0]    csum_w;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_SYNC;
            rem_q        <= 9'd0;
            sum_q        <= 8'd0;
            byte_count_q <= 8'd0;
            ptr_q        <= '0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            sum_q        <= sum_d;
            byte_count_q <= byte_count_d;
            ptr_q        <= ptr_d;
        end
    end

    assign in_ready = (state_q != ST_RUN);
    assign xfer_w   = in_valid && in_ready;
    assign csum_w   = sum_q + in_data;

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        sum_d        = sum_q;
        byte_count_d = byte_count_q;
        ptr_d        = ptr_q;
        we_w         = 1'b0;
        case (state_q)
            ST_SYNC, ST_ERR: begin
                if (xfer_w && (in_data == SYNC_BYTE)) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (xfer_w) begin
                    // A length byte of zero stands for a full 256-byte frame.
                    rem_d        = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                    sum_d        = 8'd0;
                    byte_count_d = 8'd0;
                    ptr_d        = '0;
                    state_d      = ST_DATA;
                end
            end
            ST_DATA: begin
                if (xfer_w) begin
                    we_w         = 1'b1;
                    ptr_d        = ptr_q + AW'(1);
                    sum_d        = sum_q + in_data;
                    byte_count_d = byte_count_q + 8'd1;
                    rem_d        = rem_q - 9'd1;
                    if (rem_q == 9'd1) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (xfer_w) begin
                    state_d = (csum_w == 8'd0) ? ST_RUN : ST_ERR;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase
    end

    // Flags decode straight from the state register so cpu_reset drops on
    // the same edge that enters RUN.
    assign cpu_reset  = (state_q != ST_RUN);
    assign done       = (state_q == ST_RUN);
    assign error      = (state_q == ST_ERR);
    assign byte_count = byte_count_q;

    cpu_prog_mem #(
        .AW (AW)
    ) u_mem (
        .clk   (clk),
        .we    (we_w),
        .waddr (ptr_q),
        .wdata (in_data),
        .raddr (adress),
        .rdata (dout_rom)
    );

endmodule
`default_nettype wire

// File: tb/tb_cpu_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_prog_loader
//  Brief    : Self-checking bench for cpu_prog_loader with a frame-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_prog_loader;

    localparam logic [7:0] C_SYNC = 8'hA5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic [7:0] adress = 8'h00;
    logic [7:0] dout_rom;
    logic       cpu_reset;
    logic       done;
    logic       error;
    logic [7:0] byte_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cpu_prog_loader #(
        .SYNC_BYTE (C_SYNC),
        .AW        (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .adress     (adress),
        .dout_rom   (dout_rom),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error),
        .byte_count (byte_count)
    );

    // Frame-level model: what has been loaded, whether the last frame was
    // rejected, and how far into the current frame we are.
    int  mem_m [256];
    bit  started   = 0;
    bit  loaded    = 0;
    bit  rejected  = 0;
    bit  hunting   = 1;
    bit  have_len  = 0;
    int  exp_len   = 0;
    int  got       = 0;
    int  sum       = 0;
    bit  addr_hold = 0;

    initial begin
        for (int i = 0; i < 256; i++) mem_m[i] = -1;
    end

    always @(posedge clk) begin
        if (reset) begin
            started  = 1;
            loaded   = 0;
            rejected = 0;
            hunting  = 1;
            have_len = 0;
            got      = 0;
            sum      = 0;
        end else if (in_valid && !loaded) begin
            if (hunting) begin
                if (in_data == C_SYNC) begin
                    hunting  = 0;
                    have_len = 0;
                    rejected = 0;
                end
            end else if (!have_len) begin
                exp_len  = (in_data == 8'd0) ? 256 : int'(in_data);
                have_len = 1;
                got      = 0;
                sum      = 0;
            end else if (got < exp_len) begin
                mem_m[got % 256] = int'(in_data);
                got++;
                sum += int'(in_data);
            end else begin
                if (((sum + int'(in_data)) % 256) == 0) loaded = 1;
                else rejected = 1;
                hunting = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got_v, input logic [31:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got_v, exp_v, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("in_ready",   32'(in_ready),   32'(!loaded));
            chk("cpu_reset",  32'(cpu_reset),  32'(!loaded));
            chk("done",       32'(done),       32'(loaded));
            chk("error",      32'(error),      32'(rejected));
            chk("byte_count", 32'(byte_count), 32'(got % 256));
            if (mem_m[adress] >= 0) chk("dout_rom", 32'(dout_rom), 32'(mem_m[adress]));
        end
    end

    always @(negedge clk) begin
        #1;
        if (!addr_hold) adress = adress + 8'd1;
    end

    task automatic do_reset();
        @(negedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        @(negedge clk); #1;
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] bytes [], input bit gaps);
        foreach (bytes[i]) send(bytes[i], gaps ? int'($urandom_range(0, 3)) : 0);
    endtask

    task automatic peek(input logic [7:0] a, input logic [7:0] exp_v, input string name);
        addr_hold = 1;
        @(negedge clk); #2;
        adress = a;
        #1;
        chk(name, 32'(dout_rom), 32'(exp_v));
        addr_hold = 0;
    endtask

    task automatic settle();
        @(negedge clk); #2;
    endtask

    logic [7:0] fr_a [] = '{8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'hA0};
    logic [7:0] fr_b [] = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h00};
    logic [7:0] fr_c [] = '{8'hA5, 8'h01, 8'h05, 8'hFB};
    logic [7:0] junk [] = '{8'h00, 8'hFF, 8'h5A};

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        settle();
        chk("rst_in_ready",  32'(in_ready),   32'd1);
        chk("rst_cpu_reset", 32'(cpu_reset),  32'd1);
        chk("rst_done",      32'(done),       32'd0);
        chk("rst_error",     32'(error),      32'd0);
        chk("rst_count",     32'(byte_count), 32'd0);

        // Basic valid frame; cpu_reset fall timing covered by per-cycle compare.
        send_frame(fr_a, 0);
        settle();
        chk("a_done",      32'(done),       32'd1);
        chk("a_cpu_reset", 32'(cpu_reset),  32'd0);
        chk("a_count",     32'(byte_count), 32'd3);
        peek(8'd0, 8'h10, "a_mem0");
        peek(8'd1, 8'h20, "a_mem1");
        peek(8'd2, 8'h30, "a_mem2");

        // Input ignored while running.
        send(8'hA5, 0); send(8'h01, 0); send(8'h77, 0);
        settle();
        chk("run_in_ready", 32'(in_ready), 32'd0);
        peek(8'd0, 8'h10, "run_mem0");

        // Bad checksum, then a good frame recovers.
        do_reset();
        send_frame(fr_b, 0);
        settle();
        chk("b_error",     32'(error),     32'd1);
        chk("b_cpu_reset", 32'(cpu_reset), 32'd1);
        send_frame(fr_c, 0);
        settle();
        chk("c_error", 32'(error), 32'd0);
        chk("c_done",  32'(done),  32'd1);
        peek(8'd0, 8'h05, "c_mem0");
        peek(8'd1, 8'h22, "c_mem1");

        // Leading garbage before the marker.
        do_reset();
        send_frame(junk, 0);
        send_frame(fr_a, 0);
        settle();
        chk("g_done", 32'(done), 32'd1);
        peek(8'd0, 8'h10, "g_mem0");

        // Full 256-byte frame, data = index, checksum 0x80.
        do_reset();
        send(C_SYNC, 0);
        send(8'h00, 0);
        for (int i = 0; i < 256; i++) send(8'(i), 0);
        send(8'h80, 0);
        settle();
        chk("l0_done",  32'(done),       32'd1);
        chk("l0_count", 32'(byte_count), 32'd0);
        peek(8'd255, 8'hFF, "l0_mem255");
        peek(8'd128, 8'h80, "l0_mem128");

        // Reset after two of three data bytes.
        do_reset();
        send(C_SYNC, 0); send(8'h03, 0); send(8'hAA, 0); send(8'hBB, 0);
        do_reset();
        settle();
        chk("ab_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("ab_done",      32'(done),      32'd0);
        chk("ab_in_ready",  32'(in_ready),  32'd1);
        peek(8'd0, 8'hAA, "ab_mem0");
        peek(8'd1, 8'hBB, "ab_mem1");
        peek(8'd2, 8'h02, "ab_mem2");

        // Same basic frame with random stalls.
        send_frame(fr_a, 1);
        settle();
        chk("s_done",  32'(done),       32'd1);
        chk("s_error", 32'(error),      32'd0);
        chk("s_count", 32'(byte_count), 32'd3);
        peek(8'd0, 8'h10, "s_mem0");
        peek(8'd1, 8'h20, "s_mem1");
        peek(8'd2, 8'h30, "s_mem2");
        peek(8'd3, 8'h03, "s_mem3");

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule
`default_nettype wire
